// File: rtl/pool3_flatten_reader_pkg.sv
// Shared definitions for the layer-3 pooled feature-map buffer.
// The pooling writer and the flatten reader both import this package.
// This keeps the default geometry and the raster address mapping identical on both sides.
//
// Contents:
//   P3_*        default geometry and data widths shared by writer and reader
//   rd_state_e  reader FSM state encoding
//   cnt_w()     counter width for a modulus n, never narrower than 1 bit
package pool3_flatten_reader_pkg;

    localparam int P3_DATA_W     = 12;
    localparam int P3_ADDR_W     = 8;
    localparam int P3_MAP_W      = 5;
    localparam int P3_MAP_H      = 5;
    localparam int P3_MAP_STRIDE = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool3_rd_fifo.sv
// Synchronous output FIFO for the flatten reader.
// Each entry holds one activation plus its last-element flag.
// Push and pop in the same cycle leave the count unchanged.
// This holds even when the FIFO is full.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (pointers and count only)
//   push_i   in   write din_i this cycle
//   din_i    in   entry to write
//   pop_i    in   drop the head entry this cycle (only while valid_o)
//   dout_o   out  head entry
//   valid_o  out  FIFO not empty
//   count_o  out  number of stored entries
module pool3_rd_fifo
    import pool3_flatten_reader_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW   = cnt_w(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNTW'(push_i) - CNTW'(pop_i);
    end

    // Storage is not reset; the reader gates the head entry with valid_o.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/pool3_flatten_reader.sv
// Reader side of the layer-3 pooled feature-map buffer (L4_out1 BRAM).
// After start, walks the pooled maps in raster order, row fastest:
//   addr = row + col*MAP_W + map*MAP_STRIDE
// It streams every word to the fully-connected stage over valid/ready.
// A credit check keeps (FIFO entries + reads in flight) within FIFO_DEPTH.
// Backpressure therefore never loses or duplicates BRAM data.
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset, aborts any run
//   start              in   1-cycle pulse, accepted only when idle
//   L4_out1_addr_read  out  BRAM read address
//   L4_out1_en         out  BRAM read enable, one read per high cycle
//   L4_out1_dout       in   BRAM data, valid RD_LAT cycles after the enable
//   fc_data            out  streamed activation
//   fc_valid           out  fc_data valid
//   fc_ready           in   consumer ready
//   fc_last            out  marks the final element of the run
//   busy               out  high whenever the reader is not idle
//   read_done          out  1-cycle pulse after the last handshake
module pool3_flatten_reader
    import pool3_flatten_reader_pkg::*;
#(
    parameter int DATA_W     = P3_DATA_W,
    parameter int ADDR_W     = P3_ADDR_W,
    parameter int MAP_W      = P3_MAP_W,
    parameter int MAP_H      = P3_MAP_H,
    parameter int NUM_MAPS   = 1,
    parameter int MAP_STRIDE = P3_MAP_STRIDE,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] L4_out1_addr_read,
    output logic              L4_out1_en,
    input  logic [DATA_W-1:0] L4_out1_dout,
    output logic [DATA_W-1:0] fc_data,
    output logic              fc_valid,
    input  logic              fc_ready,
    output logic              fc_last,
    output logic              busy,
    output logic              read_done
);

    localparam int RW  = cnt_w(MAP_W);
    localparam int CW  = cnt_w(MAP_H);
    localparam int MW  = cnt_w(NUM_MAPS);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    rd_state_e         state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [MW-1:0]     map_q, map_d;
    logic              en_q, en_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] pipe_en_q, pipe_last_q;

    logic              issue, elem_last, credit_ok, push, pop;
    logic              fifo_valid;
    logic [DATA_W:0]   fifo_head;
    logic [FCW-1:0]    fifo_count;
    logic [ADDR_W-1:0] addr_calc;
    int                pending;

    assign elem_last = (row_q == RW'(MAP_W - 1)) && (col_q == CW'(MAP_H - 1)) &&
                       (map_q == MW'(NUM_MAPS - 1));

    assign addr_calc = ADDR_W'(row_q) + ADDR_W'(col_q) * ADDR_W'(MAP_W) +
                       ADDR_W'(map_q) * ADDR_W'(MAP_STRIDE);

    // Entries that will occupy the FIFO once this cycle's pop happens.
    // Every read already issued (enable register plus latency pipe) is counted as owned.
    // A new read is allowed only if its slot is still free.
    always_comb begin
        pending   = int'(fifo_count) - int'(pop) + int'(en_q) + $countones(pipe_en_q);
        credit_ok = (pending < FIFO_DEPTH);
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        map_d   = map_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    row_d   = '0;
                    col_d   = '0;
                    map_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (row_q == RW'(MAP_W - 1)) begin
                        row_d = '0;
                        if (col_q == CW'(MAP_H - 1)) begin
                            col_d = '0;
                            map_d = (map_q == MW'(NUM_MAPS - 1)) ? '0 : map_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                    if (elem_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head[DATA_W]) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign en_d   = issue;
    assign last_d = issue & elem_last;
    assign addr_d = issue ? addr_calc : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            map_q       <= '0;
            en_q        <= 1'b0;
            last_q      <= 1'b0;
            addr_q      <= '0;
            pipe_en_q   <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            map_q       <= map_d;
            en_q        <= en_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            // Shift toward the MSB; the MSB lines up with valid BRAM data.
            pipe_en_q   <= RD_LAT'({pipe_en_q, en_q});
            pipe_last_q <= RD_LAT'({pipe_last_q, last_q});
        end
    end

    assign push = pipe_en_q[RD_LAT-1];
    assign pop  = fifo_valid & fc_ready;

    pool3_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({pipe_last_q[RD_LAT-1], L4_out1_dout}),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign L4_out1_addr_read = addr_q;
    assign L4_out1_en        = en_q;
    assign fc_valid          = fifo_valid;
    assign fc_data           = fifo_valid ? fifo_head[DATA_W-1:0] : '0;
    assign fc_last           = fifo_valid & fifo_head[DATA_W];
    assign busy              = (state_q != ST_IDLE);
    assign read_done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_pool3_flatten_reader.sv
// Bench for pool3_flatten_reader.
// Instance 0 uses the default geometry.
// Instance 1 uses RD_LAT=3, NUM_MAPS=2, MAP_STRIDE=32 and FIFO_DEPTH=5.
// A BRAM model returns addr+100 after the configured latency, and random data otherwise.
// A single compare process on the falling edge checks both instances against a raster-order model.
module tb_pool3_flatten_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st     [2];
    logic        rdy    [2];
    logic        en_s   [2];
    logic        vld_s  [2];
    logic        last_s [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic [7:0]  addr_s [2];
    logic [11:0] dout_s [2];
    logic [11:0] data_s [2];
    logic [11:0] b1_s0, b1_s1;

    pool3_flatten_reader dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .L4_out1_addr_read(addr_s[0]), .L4_out1_en(en_s[0]), .L4_out1_dout(dout_s[0]),
        .fc_data(data_s[0]), .fc_valid(vld_s[0]), .fc_ready(rdy[0]), .fc_last(last_s[0]),
        .busy(busy_s[0]), .read_done(done_s[0])
    );

    pool3_flatten_reader #(.RD_LAT(3), .NUM_MAPS(2), .MAP_STRIDE(32), .FIFO_DEPTH(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .L4_out1_addr_read(addr_s[1]), .L4_out1_en(en_s[1]), .L4_out1_dout(dout_s[1]),
        .fc_data(data_s[1]), .fc_valid(vld_s[1]), .fc_ready(rdy[1]), .fc_last(last_s[1]),
        .busy(busy_s[1]), .read_done(done_s[1])
    );

    function automatic logic [11:0] bram_word(input logic [7:0] a);
        return 12'(a) + 12'd100;
    endfunction

    always @(posedge clk) begin
        dout_s[0] <= en_s[0] ? bram_word(addr_s[0]) : 12'($urandom);
        b1_s0     <= en_s[1] ? bram_word(addr_s[1]) : 12'($urandom);
        b1_s1     <= b1_s0;
        dout_s[1] <= b1_s1;
    end

    // Reference model: geometry of each instance and the raster walk.
    function automatic int n_beats(input int k);  return (k == 0) ? 25 : 50; endfunction
    function automatic int stride(input int k);   return (k == 0) ? 25 : 32; endfunction
    function automatic int fifo_dep(input int k); return (k == 0) ? 4 : 5;   endfunction

    function automatic int model_addr(input int k, input int idx);
        int row, col, map;
        row = idx % 5;
        col = (idx / 5) % 5;
        map = idx / 25;
        return row + col * 5 + map * stride(k);
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    int cyc = 0;
    bit active [2], pend_done [2], prev_stall [2], prev_last [2], seen_v [2];
    int exp_idx [2], iss_idx [2], dones [2], prev_data [2];
    int acc_cyc [2], first_v_cyc [2], first_hs_cyc [2], last_hs_cyc [2];
    int first_data [2], last_data [2], first_addr [2], addr25 [2];

    task automatic observe(input int k);
        int  n;
        bit  hs, done_exp;
        n        = n_beats(k);
        hs       = vld_s[k] && rdy[k];
        done_exp = pend_done[k];
        chk($sformatf("read_done%0d", k), int'(done_s[k]), int'(done_exp));
        chk($sformatf("busy%0d", k), int'(busy_s[k]), int'(active[k]));
        if (done_s[k]) dones[k]++;
        if (prev_stall[k]) begin
            chk($sformatf("hold_valid%0d", k), int'(vld_s[k]), 1);
            chk($sformatf("hold_data%0d", k), int'(data_s[k]), prev_data[k]);
            chk($sformatf("hold_last%0d", k), int'(last_s[k]), int'(prev_last[k]));
        end
        if (en_s[k]) begin
            chk($sformatf("issue_in_run%0d", k), int'(active[k] && iss_idx[k] < n), 1);
            if (iss_idx[k] < n)
                chk($sformatf("addr%0d_idx%0d", k, iss_idx[k]), int'(addr_s[k]),
                    model_addr(k, iss_idx[k]));
            if (iss_idx[k] == 0)  first_addr[k] = int'(addr_s[k]);
            if (iss_idx[k] == 25) addr25[k] = int'(addr_s[k]);
            iss_idx[k]++;
        end
        if (active[k])
            chk($sformatf("credit%0d", k), int'(iss_idx[k] - exp_idx[k] <= fifo_dep(k)), 1);
        if (vld_s[k] && active[k] && !seen_v[k]) begin
            seen_v[k] = 1'b1;
            first_v_cyc[k] = cyc;
        end
        pend_done[k] = 1'b0;
        if (hs) begin
            chk($sformatf("beat_in_run%0d", k), int'(active[k] && exp_idx[k] < n), 1);
            if (exp_idx[k] < n) begin
                chk($sformatf("data%0d_beat%0d", k, exp_idx[k]), int'(data_s[k]),
                    model_addr(k, exp_idx[k]) + 100);
                chk($sformatf("last%0d_beat%0d", k, exp_idx[k]), int'(last_s[k]),
                    int'(exp_idx[k] == n - 1));
            end
            if (exp_idx[k] == 0) begin
                first_hs_cyc[k] = cyc;
                first_data[k]   = int'(data_s[k]);
            end
            if (exp_idx[k] == n - 1) begin
                last_hs_cyc[k] = cyc;
                last_data[k]   = int'(data_s[k]);
                pend_done[k]   = 1'b1;
            end
            exp_idx[k]++;
        end
        prev_stall[k] = vld_s[k] && !rdy[k];
        prev_data[k]  = int'(data_s[k]);
        prev_last[k]  = last_s[k];
        if (done_exp) begin
            active[k] = 1'b0;
        end else if (!active[k] && st[k]) begin
            active[k]  = 1'b1;
            exp_idx[k] = 0;
            iss_idx[k] = 0;
            seen_v[k]  = 1'b0;
            acc_cyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                active[k]     = 1'b0;
                pend_done[k]  = 1'b0;
                prev_stall[k] = 1'b0;
                exp_idx[k]    = 0;
                iss_idx[k]    = 0;
            end else begin
                observe(k);
            end
        end
    end

    task automatic check_zero(input int k, input string tag);
        chk($sformatf("%s_en%0d", tag, k),    int'(en_s[k]),   0);
        chk($sformatf("%s_addr%0d", tag, k),  int'(addr_s[k]), 0);
        chk($sformatf("%s_valid%0d", tag, k), int'(vld_s[k]),  0);
        chk($sformatf("%s_data%0d", tag, k),  int'(data_s[k]), 0);
        chk($sformatf("%s_last%0d", tag, k),  int'(last_s[k]), 0);
        chk($sformatf("%s_busy%0d", tag, k),  int'(busy_s[k]), 0);
        chk($sformatf("%s_done%0d", tag, k),  int'(done_s[k]), 0);
    endtask

    // mode 0: ready held high; 1: random ready; 2: ready low for 20 cycles then high.
    // restart_at >= 0 pulses start again at that beat.
    // rst_at >= 0 asserts reset at that beat and returns.
    task automatic run(input int k, input int mode, input int restart_at, input int rst_at);
        bit restarted;
        int d0;
        restarted = 1'b0;
        d0        = dones[k];
        st[k]     = 1'b1;
        rdy[k]    = (mode == 0);
        @(posedge clk); #1;
        st[k] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            case (mode)
                0:       rdy[k] = 1'b1;
                1:       rdy[k] = 1'($urandom_range(0, 1));
                default: rdy[k] = (c >= 20);
            endcase
            if (mode == 2 && c == 20) begin
                chk("stall_reads_issued", iss_idx[k], fifo_dep(k));
                chk("stall_en_low", int'(en_s[k]), 0);
            end
            if (restart_at >= 0 && !restarted && exp_idx[k] >= restart_at) begin
                st[k]     = 1'b1;
                restarted = 1'b1;
            end else begin
                st[k] = 1'b0;
            end
            if (rst_at >= 0 && exp_idx[k] >= rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_zero(k, "async_rst");
                return;
            end
            if (dones[k] != d0) break;
            @(posedge clk); #1;
        end
        st[k] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("run_done_count%0d", k), dones[k] - d0, 1);
        chk($sformatf("run_beats%0d", k), exp_idx[k], n_beats(k));
        chk($sformatf("busy_after%0d", k), int'(busy_s[k]), 0);
    endtask

    task automatic post_full(input int k, input int exp_lat, input int exp_last);
        chk($sformatf("latency%0d", k), first_v_cyc[k] - acc_cyc[k], exp_lat);
        chk($sformatf("throughput%0d", k), last_hs_cyc[k] - first_hs_cyc[k], n_beats(k) - 1);
        chk($sformatf("first_data%0d", k), first_data[k], 100);
        chk($sformatf("last_data%0d", k), last_data[k], exp_last);
        chk($sformatf("first_addr%0d", k), first_addr[k], 0);
    endtask

    initial begin
        int d5;
        rst_n  = 1'b0;
        st[0]  = 1'b0;
        st[1]  = 1'b0;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 0, -1, -1);
        post_full(0, 4, 124);

        run(0, 1, -1, -1);

        run(0, 2, -1, -1);

        run(0, 0, 10, -1);

        d5 = dones[0];
        run(0, 0, -1, 12);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_read_done", dones[0] - d5, 0);
        run(0, 0, -1, -1);
        post_full(0, 4, 124);

        run(1, 0, -1, -1);
        post_full(1, 6, 156);
        chk("map1_first_addr", addr25[1], 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
